// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed stores; optional load forwarding (STBUF_FORWARD_EN).
// Latency: a pushed store drains no earlier than the next cycle; a load response comes 1 cycle after rd.
// Backpressure: push_ready drops when full; drain_stall holds the head; without forwarding, loads wait for empty.
module store_buffer #(
    parameter int STBUF_DEPTH    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int SIZE_WIDTH     = 2,
    parameter int REG_DATA_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stbuf_push_valid,
    input  logic [ADDR_WIDTH-1:0]     stbuf_push_addr,
    input  logic [SIZE_WIDTH-1:0]     stbuf_push_size,
    input  logic [REG_DATA_WIDTH-1:0] stbuf_push_data,
    output logic                      stbuf_push_ready,
    output logic                      stbuf_empty,
    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
    output logic [REG_DATA_WIDTH-1:0] bus_tcm_stbuf_data,
    output logic                      bus_tcm_stbuf_wr,
    input  logic                      stbuf_drain_stall,
    input  logic                      stbuf_load_valid,
    input  logic [ADDR_WIDTH-1:0]     stbuf_load_addr,
    input  logic [SIZE_WIDTH-1:0]     stbuf_load_size,
    output logic                      stbuf_load_ready,
    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
    output logic                      bus_tcm_stbuf_rd,
    input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data,
    output logic                      stbuf_load_resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_load_resp_data
);

    localparam int                  PTR_W    = $clog2(STBUF_DEPTH);
    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W+1)'(STBUF_DEPTH);
    localparam logic [SIZE_WIDTH-1:0] SIZE_INV = SIZE_WIDTH'(3);

    logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0]     ent_addr_q [STBUF_DEPTH];
    logic [ADDR_WIDTH-1:0]     ent_addr_d [STBUF_DEPTH];
    logic [SIZE_WIDTH-1:0]     ent_size_q [STBUF_DEPTH];
    logic [SIZE_WIDTH-1:0]     ent_size_d [STBUF_DEPTH];
    logic [REG_DATA_WIDTH-1:0] ent_data_q [STBUF_DEPTH];
    logic [REG_DATA_WIDTH-1:0] ent_data_d [STBUF_DEPTH];
    logic                      resp_valid_q, resp_valid_d;
    logic                      push_fire, pop_fire, load_fire;

    assign stbuf_empty      = (count_q == '0);
    assign stbuf_push_ready = (count_q != FULL_CNT);
    assign push_fire        = stbuf_push_valid && stbuf_push_ready;
    assign pop_fire         = !stbuf_empty && !stbuf_drain_stall;

    assign bus_tcm_stbuf_write_addr = ent_addr_q[head_q];
    assign bus_tcm_stbuf_write_size = ent_size_q[head_q];
    assign bus_tcm_stbuf_data       = ent_data_q[head_q];
    // Invalid-size entries still leave the queue; only the strobe is withheld.
    assign bus_tcm_stbuf_wr         = pop_fire && (ent_size_q[head_q] != SIZE_INV);

    assign bus_tcm_stbuf_read_addr = stbuf_load_addr;
    assign bus_tcm_stbuf_read_size = stbuf_load_size;
    assign load_fire               = stbuf_load_valid && stbuf_load_ready && rst;
    assign bus_tcm_stbuf_rd        = load_fire;
    assign resp_valid_d            = load_fire;
    assign stbuf_load_resp_valid   = resp_valid_q;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ent_addr_d = ent_addr_q;
        ent_size_d = ent_size_q;
        ent_data_d = ent_data_q;
        if (push_fire) begin
            ent_addr_d[tail_q] = stbuf_push_addr;
            ent_size_d[tail_q] = stbuf_push_size;
            ent_data_d[tail_q] = stbuf_push_data;
            tail_d             = tail_q + PTR_W'(1);
        end
        if (pop_fire) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push_fire && !pop_fire) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push_fire && pop_fire) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_size_q <= ent_size_d;
        ent_data_q <= ent_data_d;
    end

`ifdef STBUF_FORWARD_EN
    localparam int NB = BUS_DATA_WIDTH / 8;
    localparam int RB = REG_DATA_WIDTH / 8;

    logic [NB-1:0]             hit_q, hit_d;
    logic [BUS_DATA_WIDTH-1:0] fwd_q, fwd_d;
    logic [BUS_DATA_WIDTH-1:0] merged;

    assign stbuf_load_ready = 1'b1;

    // Walk oldest to youngest so the youngest matching entry wins each byte.
    always_comb begin
        logic [ADDR_WIDTH-1:0] byte_addr;
        logic [ADDR_WIDTH-1:0] off;
        logic [PTR_W-1:0]      idx;
        int                    ld_bytes;
        hit_d     = '0;
        fwd_d     = '0;
        byte_addr = '0;
        off       = '0;
        idx       = '0;
        ld_bytes  = 32'(1) << stbuf_load_size;
        for (int k = 0; k < NB; k++) begin
            if (load_fire && (k < ld_bytes)) begin
                byte_addr = stbuf_load_addr + ADDR_WIDTH'(k);
                for (int i = 0; i < STBUF_DEPTH; i++) begin
                    idx = head_q + PTR_W'(i);
                    off = byte_addr - ent_addr_q[idx];
                    // Invalid-size entries are never written, so they never supply data.
                    if (((PTR_W+1)'(i) < count_q) && (ent_size_q[idx] != SIZE_INV) &&
                        (off < (ADDR_WIDTH'(1) << ent_size_q[idx]))) begin
                        for (int b = 0; b < RB; b++) begin
                            if (off == ADDR_WIDTH'(b)) begin
                                hit_d[k]        = 1'b1;
                                fwd_d[8*k +: 8] = ent_data_q[idx][8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= '0;
            fwd_q <= '0;
        end else begin
            hit_q <= hit_d;
            fwd_q <= fwd_d;
        end
    end

    always_comb begin
        merged = tcm_bus_stbuf_data;
        for (int k = 0; k < NB; k++) begin
            if (hit_q[k]) begin
                merged[8*k +: 8] = fwd_q[8*k +: 8];
            end
        end
    end

    assign stbuf_load_resp_data = rst ? merged : '0;
`else
    assign stbuf_load_ready     = stbuf_empty;
    assign stbuf_load_resp_data = rst ? tcm_bus_stbuf_data : '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected writes and load responses queued at issue, compared on output.
module tb_store_buffer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stbuf_push_valid;
    logic [31:0] stbuf_push_addr;
    logic [1:0]  stbuf_push_size;
    logic [31:0] stbuf_push_data;
    logic        stbuf_push_ready;
    logic        stbuf_empty;
    logic [31:0] bus_tcm_stbuf_write_addr;
    logic [1:0]  bus_tcm_stbuf_write_size;
    logic [31:0] bus_tcm_stbuf_data;
    logic        bus_tcm_stbuf_wr;
    logic        stbuf_drain_stall;
    logic        stbuf_load_valid;
    logic [31:0] stbuf_load_addr;
    logic [1:0]  stbuf_load_size;
    logic        stbuf_load_ready;
    logic [31:0] bus_tcm_stbuf_read_addr;
    logic [1:0]  bus_tcm_stbuf_read_size;
    logic        bus_tcm_stbuf_rd;
    logic [31:0] tcm_bus_stbuf_data;
    logic        stbuf_load_resp_valid;
    logic [31:0] stbuf_load_resp_data;

    store_buffer dut (
        .clk                      (clk),
        .rst                      (rst),
        .stbuf_push_valid         (stbuf_push_valid),
        .stbuf_push_addr          (stbuf_push_addr),
        .stbuf_push_size          (stbuf_push_size),
        .stbuf_push_data          (stbuf_push_data),
        .stbuf_push_ready         (stbuf_push_ready),
        .stbuf_empty              (stbuf_empty),
        .bus_tcm_stbuf_write_addr (bus_tcm_stbuf_write_addr),
        .bus_tcm_stbuf_write_size (bus_tcm_stbuf_write_size),
        .bus_tcm_stbuf_data       (bus_tcm_stbuf_data),
        .bus_tcm_stbuf_wr         (bus_tcm_stbuf_wr),
        .stbuf_drain_stall        (stbuf_drain_stall),
        .stbuf_load_valid         (stbuf_load_valid),
        .stbuf_load_addr          (stbuf_load_addr),
        .stbuf_load_size          (stbuf_load_size),
        .stbuf_load_ready         (stbuf_load_ready),
        .bus_tcm_stbuf_read_addr  (bus_tcm_stbuf_read_addr),
        .bus_tcm_stbuf_read_size  (bus_tcm_stbuf_read_size),
        .bus_tcm_stbuf_rd         (bus_tcm_stbuf_rd),
        .tcm_bus_stbuf_data       (tcm_bus_stbuf_data),
        .stbuf_load_resp_valid    (stbuf_load_resp_valid),
        .stbuf_load_resp_data     (stbuf_load_resp_data)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] d;
    } st_t;

    st_t         exp_wr[$];
    logic [31:0] exp_rsp[$];
    int          err_cnt = 0;
    int          chk_cnt = 0;
    int          wr_cnt  = 0;
    int          wr_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        st_t         e;
        logic [31:0] r;
        if (bus_tcm_stbuf_wr) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 32'(bus_tcm_stbuf_wr), 0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", bus_tcm_stbuf_write_addr, e.a);
                chk("wr_size", 32'(bus_tcm_stbuf_write_size), 32'(e.s));
                chk("wr_data", bus_tcm_stbuf_data, e.d);
            end
        end
        if (stbuf_load_resp_valid) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", 32'(stbuf_load_resp_valid), 0);
            end else begin
                r = exp_rsp.pop_front();
                chk("rsp_data", stbuf_load_resp_data, r);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        stbuf_push_valid = 1'b1;
        stbuf_push_addr  = a;
        stbuf_push_size  = s;
        stbuf_push_data  = d;
        #1;
        chk("push_ready", 32'(stbuf_push_ready), 1);
        if (stbuf_push_ready && s != 2'd3) exp_wr.push_back('{a: a, s: s, d: d});
        cyc();
        stbuf_push_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input logic [31:0] exp);
        int n = 0;
        stbuf_load_valid = 1'b1;
        stbuf_load_addr  = a;
        stbuf_load_size  = s;
        #1;
        while (!stbuf_load_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("load_ready", 32'(stbuf_load_ready), 1);
        chk("rd_strobe", 32'(bus_tcm_stbuf_rd), 1);
        chk("rd_addr", bus_tcm_stbuf_read_addr, a);
        if (bus_tcm_stbuf_rd) exp_rsp.push_back(exp);
        cyc();
        stbuf_load_valid = 1'b0;
        cyc();
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!stbuf_empty && n < 20) begin
            cyc();
            n++;
        end
        chk("drain_done", 32'(stbuf_empty), 1);
    endtask

    initial begin
        rst                = 1'b1;
        stbuf_push_valid   = 1'b0;
        stbuf_push_addr    = '0;
        stbuf_push_size    = '0;
        stbuf_push_data    = '0;
        stbuf_drain_stall  = 1'b0;
        stbuf_load_valid   = 1'b1;
        stbuf_load_addr    = 32'h40;
        stbuf_load_size    = 2'd2;
        tcm_bus_stbuf_data = 32'hA5A5A5A5;
        #2 rst = 1'b0;
        #1;
        chk("rst_push_ready", 32'(stbuf_push_ready), 1);
        chk("rst_empty", 32'(stbuf_empty), 1);
        chk("rst_wr", 32'(bus_tcm_stbuf_wr), 0);
        chk("rst_rd", 32'(bus_tcm_stbuf_rd), 0);
        chk("rst_rsp_valid", 32'(stbuf_load_resp_valid), 0);
        chk("rst_rsp_data", stbuf_load_resp_data, 0);
        cyc();
        cyc();
        rst              = 1'b1;
        stbuf_load_valid = 1'b0;
        cyc();

        // Fill under stall, refuse a push while full even as the head drains.
        stbuf_drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) do_push(32'h200 + 32'(4*i), 2'd2, 32'h10000000 + 32'(i*32'h111));
        chk("full_ready", 32'(stbuf_push_ready), 0);
        chk("stall_no_wr", 32'(bus_tcm_stbuf_wr), 0);
        wr_base           = wr_cnt;
        stbuf_drain_stall = 1'b0;
        stbuf_push_valid  = 1'b1;
        stbuf_push_addr   = 32'h2F0;
        stbuf_push_size   = 2'd2;
        stbuf_push_data   = 32'hBAD0BAD0;
        #1;
        chk("full_refuse", 32'(stbuf_push_ready), 0);
        cyc();
        stbuf_push_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("burst_empty", 32'(stbuf_empty), 1);
        chk("burst_wr_cnt", 32'(wr_cnt - wr_base), 4);

        // Invalid size: popped without a strobe.
        stbuf_drain_stall = 1'b1;
        do_push(32'h600, 2'd3, 32'hFFFFFFFF);
        do_push(32'h604, 2'd2, 32'h0BADCAFE);
        wr_base           = wr_cnt;
        stbuf_drain_stall = 1'b0;
        cyc();
        cyc();
        chk("inv_empty", 32'(stbuf_empty), 1);
        chk("inv_wr_cnt", 32'(wr_cnt - wr_base), 1);

`ifdef STBUF_FORWARD_EN
        stbuf_drain_stall  = 1'b1;
        tcm_bus_stbuf_data = 32'hDEADBEEF;
        do_push(32'h100, 2'd2, 32'h11223344);
        chk("fwd_ld_ready", 32'(stbuf_load_ready), 1);
        do_load(32'h100, 2'd2, 32'h11223344);
        do_load(32'h102, 2'd1, 32'hDEAD1122);
        do_load(32'h0FE, 2'd2, 32'h3344BEEF);
        do_load(32'h103, 2'd0, 32'hDEADBE11);
        stbuf_drain_stall = 1'b0;
        wait_empty();

        stbuf_drain_stall  = 1'b1;
        tcm_bus_stbuf_data = 32'h00000000;
        do_push(32'h101, 2'd0, 32'h000000AA);
        do_push(32'h101, 2'd0, 32'h000000BB);
        do_load(32'h100, 2'd2, 32'h0000BB00);
        stbuf_drain_stall = 1'b0;
        wait_empty();

        // Load meets the draining entry while a younger push arrives the same cycle.
        stbuf_drain_stall = 1'b1;
        do_push(32'h300, 2'd2, 32'hCAFEF00D);
        stbuf_drain_stall = 1'b0;
        stbuf_push_valid  = 1'b1;
        stbuf_push_addr   = 32'h300;
        stbuf_push_size   = 2'd2;
        stbuf_push_data   = 32'h12345678;
        stbuf_load_valid  = 1'b1;
        stbuf_load_addr   = 32'h300;
        stbuf_load_size   = 2'd2;
        #1;
        chk("same_push_ready", 32'(stbuf_push_ready), 1);
        chk("same_rd", 32'(bus_tcm_stbuf_rd), 1);
        if (stbuf_push_ready) exp_wr.push_back('{a: 32'h300, s: 2'd2, d: 32'h12345678});
        if (bus_tcm_stbuf_rd) exp_rsp.push_back(32'hCAFEF00D);
        cyc();
        stbuf_push_valid = 1'b0;
        stbuf_load_valid = 1'b0;
        cyc();
        wait_empty();

        tcm_bus_stbuf_data = 32'h5A5A5A5A;
        stbuf_push_valid   = 1'b1;
        stbuf_push_addr    = 32'h400;
        stbuf_push_size    = 2'd0;
        stbuf_push_data    = 32'h00000099;
        stbuf_load_valid   = 1'b1;
        stbuf_load_addr    = 32'h400;
        stbuf_load_size    = 2'd2;
        #1;
        chk("empty_push_ready", 32'(stbuf_push_ready), 1);
        chk("empty_rd", 32'(bus_tcm_stbuf_rd), 1);
        if (stbuf_push_ready) exp_wr.push_back('{a: 32'h400, s: 2'd0, d: 32'h00000099});
        if (bus_tcm_stbuf_rd) exp_rsp.push_back(32'h5A5A5A5A);
        cyc();
        stbuf_push_valid = 1'b0;
        stbuf_load_valid = 1'b0;
        cyc();
        wait_empty();
`else
        // Without forwarding, loads wait for the buffer to empty and see raw TCM data.
        stbuf_drain_stall  = 1'b1;
        tcm_bus_stbuf_data = 32'h76543210;
        do_push(32'h500, 2'd2, 32'hAAAAAAAA);
        stbuf_load_valid = 1'b1;
        stbuf_load_addr  = 32'h500;
        stbuf_load_size  = 2'd2;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ld_blocked", 32'(stbuf_load_ready), 0);
            chk("rd_blocked", 32'(bus_tcm_stbuf_rd), 0);
            cyc();
        end
        stbuf_drain_stall = 1'b0;
        do_load(32'h500, 2'd2, 32'h76543210);
        chk("nofwd_empty", 32'(stbuf_empty), 1);
`endif

        // Reset with pending entries (and a load in flight when forwarding).
        stbuf_drain_stall  = 1'b1;
        tcm_bus_stbuf_data = 32'hFFFFFFFF;
        do_push(32'h700, 2'd2, 32'h01010101);
        do_push(32'h704, 2'd2, 32'h02020202);
        do_push(32'h708, 2'd2, 32'h03030303);
`ifdef STBUF_FORWARD_EN
        stbuf_load_valid = 1'b1;
        stbuf_load_addr  = 32'h700;
        stbuf_load_size  = 2'd2;
        cyc();
        stbuf_load_valid = 1'b0;
        chk("rsp_inflight", 32'(stbuf_load_resp_valid), 1);
`endif
        rst               = 1'b0;
        exp_wr.delete();
        stbuf_drain_stall = 1'b0;
        stbuf_load_valid  = 1'b1;
        #1;
        chk("rst2_empty", 32'(stbuf_empty), 1);
        chk("rst2_push_ready", 32'(stbuf_push_ready), 1);
        chk("rst2_rsp_valid", 32'(stbuf_load_resp_valid), 0);
        chk("rst2_rsp_data", stbuf_load_resp_data, 0);
        chk("rst2_wr", 32'(bus_tcm_stbuf_wr), 0);
        chk("rst2_rd", 32'(bus_tcm_stbuf_rd), 0);
        cyc();
        cyc();
        rst              = 1'b1;
        stbuf_load_valid = 1'b0;
        chk("post_rst_empty", 32'(stbuf_empty), 1);
        do_push(32'h800, 2'd1, 32'h0000BEEF);
        wait_empty();

        repeat (3) cyc();
        chk("sb_wr_left", exp_wr.size(), 0);
        chk("sb_rsp_left", exp_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer
Interface
REQ-001 SHALL have parameter STBUF_DEPTH, default 4, meaning number of entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port stbuf_push_valid  input  1  committed store offered.
REQ-005 SHALL have port stbuf_push_addr  input  ADDR_WIDTH  store byte address.
REQ-006 SHALL have port stbuf_push_size  input  SIZE_WIDTH  0=byte, 1=half, 2=word, 3=invalid.
REQ-007 SHALL have port stbuf_push_data  input  REG_DATA_WIDTH  store data; byte i goes to addr+i.
REQ-008 SHALL have port stbuf_push_ready  output  1  entry available.
REQ-009 SHALL have port stbuf_empty  output  1  no valid entries (fence support).
REQ-010 SHALL have port bus_tcm_stbuf_write_addr  output  ADDR_WIDTH  head entry address.
REQ-011 SHALL have port bus_tcm_stbuf_write_size  output  SIZE_WIDTH  head entry size.
REQ-012 SHALL have port bus_tcm_stbuf_data  output  REG_DATA_WIDTH  head entry data.
REQ-013 SHALL have port bus_tcm_stbuf_wr  output  1  write strobe; TCM accepts every strobed cycle.
REQ-014 SHALL have port stbuf_drain_stall  input  1  blocks draining this cycle.
REQ-015 SHALL have port stbuf_load_valid, stbuf_load_addr (ADDR_WIDTH), stbuf_load_size (SIZE_WIDTH)  input  load request.
REQ-016 SHALL have port stbuf_load_ready  output  1  load request accepted this cycle.
REQ-017 SHALL have port bus_tcm_stbuf_read_addr / bus_tcm_stbuf_read_size / bus_tcm_stbuf_rd  output  ADDR_WIDTH/SIZE_WIDTH/1  combinational pass-through of load request; rd = valid & ready.
REQ-018 SHALL have port tcm_bus_stbuf_data  input  BUS_DATA_WIDTH  TCM read data, one cycle after rd; byte k = address addr+k.
REQ-019 SHALL have port stbuf_load_resp_valid / stbuf_load_resp_data  output  1/BUS_DATA_WIDTH  merged load response.
Function
REQ-020 SHALL hold entries in a circular FIFO with head/tail pointers and an occupancy count 0..STBUF_DEPTH; pointers wrap modulo STBUF_DEPTH.
REQ-021 SHALL set push_ready = (count != STBUF_DEPTH); a push enqueues when valid & ready; full with a same-cycle drain still refuses the push.
REQ-022 SHALL assert bus_tcm_stbuf_wr = !empty & !drain_stall, drive head fields combinationally, and pop the head at that edge (one store per cycle).
REQ-023 SHALL enqueue and pop simultaneously without count change when both occur; push into an empty buffer is drained no earlier than the next cycle.
REQ-024 SHALL treat size 3 on push as a valid entry whose wr strobe is suppressed while it is popped normally.
REQ-025 SHALL register a load one cycle after rd: stbuf_load_resp_valid=1 for exactly one cycle, aligned with tcm_bus_stbuf_data.
REQ-026 SHALL compute, for each load byte k < (1<<load_size), the youngest entry e valid in the request cycle (including the entry draining that cycle, excluding a same-cycle push) with (addr+k - e.addr) mod 2^ADDR_WIDTH < (1<<e.size); register hit mask and byte.
REQ-027 SHALL output resp byte k = hit ? forwarded byte : TCM byte k; bytes k >= (1<<load_size) pass TCM data unmodified.
Reset
REQ-028 SHALL on rst low immediately clear pointers, count, and resp_valid, discarding entries and any in-flight load; outputs: push_ready=1, stbuf_empty=1, wr=0, rd=0, resp_valid=0, resp_data=0.
REQ-029 SHALL resume normal operation on the first posedge after rst deasserts.
Configuration
REQ-030 SHALL, with STBUF_FORWARD_EN defined, implement REQ-026/027 and drive stbuf_load_ready=1.
REQ-031 SHALL, without STBUF_FORWARD_EN, drive stbuf_load_ready=stbuf_empty and resp_data=tcm_bus_stbuf_data, with no forwarding logic.
Verification
REQ-032 SHALL test: 4 pushes with drain_stall=1 -> push_ready=0 after 4th; release stall -> 4 wr strobes on consecutive cycles, stbuf_empty=1 after.
REQ-033 SHALL test: push word 0x11223344 @0x100, stall, load word @0x100 (forward on) -> resp 0x11223344 next cycle regardless of TCM data.
REQ-034 SHALL test: push byte 0xAA @0x101 then byte 0xBB @0x101, load word @0x100, TCM=0x00000000 -> resp 0x0000BB00.
REQ-035 SHALL test: load issued in the same cycle as the matching entry drains -> forwarded value returned; same-cycle push not forwarded.
REQ-036 SHALL test: rst low with 3 entries and a load in flight -> stbuf_empty=1, resp_valid=0 immediately, no further wr.
REQ-037 SHALL test: forward off, one pending entry -> stbuf_load_ready=0 until drained, then resp equals TCM data.
